hid_uart_arbiter: RTL and testbench
===================================

# hid_uart_arbiter

Packet-level round-robin arbiter that shares the single UART byte transmitter between several report printers: keyboard, mouse, gamepad and raw-report dump. It sits between those byte streams and the UART serializer in the `clk_usb` domain. Each grant is held until the owning requester delivers its last byte, so printed lines never interleave. An optional stall timeout reclaims the UART from a requester that hangs mid-packet.

## Interface
Parameters:
- `N`, 3: number of requesters; legal range 1..8.
- `TIMEOUT`, 255: idle cycles tolerated mid-packet before a forced release. Only used with `HID_ARB_TIMEOUT_EN`; legal range 1..65535.

Ports:
- `clk`  in  1  single clock, the 12 MHz `clk_usb` domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N  per-requester byte valid.
- `req_data`  in  8N  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  N  qualifies the current byte as the final byte of the packet.
- `req_ready`  out  N  per-requester byte accepted.
- `tx_valid`  out  1  byte offered to the UART serializer.
- `tx_data`  out  8  byte to the serializer.
- `tx_ready`  in  1  serializer accepts the byte this cycle.
- `grant`  out  N  one-hot current owner; all zeros when idle.
- `busy`  out  1  a packet is in progress.
- `abort`  out  1  one-cycle pulse on a timeout release; constant 0 without the macro.

## Operation
- States: IDLE, BUSY. Registered state: `state`, `grant`, `last_idx` (index of the previous owner), and the timeout counter `stall_cnt` when enabled.
- Reset values:
  - state=IDLE, grant=0, busy=0, abort=0, last_idx=N-1, so requester 0 wins first.
  - Combinational outputs at reset: tx_valid=0, tx_data=0, req_ready=0.
- IDLE:
  - tx_valid=0, tx_data=0, req_ready=0. tx_ready is ignored.
  - If any req_valid bit is set, select the first set bit searching upward from last_idx+1 modulo N.
  - Load grant with that one-hot and move to BUSY on the next edge.
  - If no req_valid bit is set, stay in IDLE.
- BUSY, with owner g:
  - tx_valid = req_valid[g], tx_data = req_data[g] (combinational pass-through, no buffering).
  - req_ready[g] = tx_ready. All other req_ready bits are 0.
  - A handshake is req_valid[g] & tx_ready.
  - A handshake with req_last[g]=1 returns to IDLE: last_idx=g, grant=0.
  - Non-owner req_valid bits are ignored until the next IDLE.
- Requesters hold req_data/req_last stable while valid and not ready. The arbiter does not check this.
- busy = (state==BUSY). grant is a registered output.
- N=1: the arbiter degenerates to a pass-through with the one-cycle IDLE gap.

## Timing
- Arbitration latency: a request sampled in IDLE at edge k gives grant and tx_valid at cycle k+1.
- Pass-through: zero latency from req_valid/req_data to tx_valid/tx_data in BUSY. The same holds for tx_ready to req_ready.
- Packet gap: the edge that accepts the last byte returns to IDLE. The earliest next grant is two cycles after the last-byte handshake. A back-to-back request by the same requester is re-arbitrated and loses to any other pending requester.
- A requester may drop req_valid mid-packet. The UART then stalls and the grant is held.
- rst asserted in any state returns every register to its reset value on that edge and overrides any simultaneous handshake or timeout. The serializer sees tx_valid=0 from the following cycle. A byte accepted on the reset edge is the requester's responsibility.

## Configuration
- `HID_ARB_TIMEOUT_EN` defined:
  - In BUSY, stall_cnt increments on each cycle with req_valid[g]=0, clears on any handshake, and clears on entering BUSY.
  - When stall_cnt reaches TIMEOUT, the next edge forces IDLE with last_idx=g, grant=0, and abort=1 for one cycle.
  - If a handshake and the timeout threshold occur in the same cycle, the handshake wins.
- `HID_ARB_TIMEOUT_EN` undefined: no counter; abort is tied to 0; the grant is held indefinitely until req_last.

## Test plan
- Reset, then requester 1 sends 3 bytes 0x41, 0x42, 0x0A (last on 0x0A) with tx_ready=1 -> grant=3'b010 one cycle after the request; tx_data sequence 0x41, 0x42, 0x0A; busy falls after 0x0A.
- Requesters 0, 1 and 2 all request continuously with 2-byte packets -> grant order 0, 1, 2, 0; bytes never interleave within a packet.
- Requester 0 is mid-packet when requester 2 asserts valid; tx_ready toggles every other cycle -> grant stays 3'b001 until the last byte; req_ready[0] mirrors tx_ready; req_ready[2]=0 throughout.
- With the macro and TIMEOUT=4: requester 0 sends one non-last byte, then drops valid -> abort pulses exactly once, 4 stall cycles later; the next grant goes to a pending requester 1.
- Assert rst while BUSY with tx_ready=1 and a last byte pending -> the next cycle shows grant=0, busy=0, tx_valid=0, and last_idx=N-1 (requester 0 wins the next arbitration).

Source files
------------

// File: rtl/hid_uart_arbiter.sv
// hid_uart_arbiter: packet-level round-robin arbiter sharing one UART byte transmitter among N report printers; ports clk, rst (sync active-high), req_valid/req_data/req_last/req_ready per requester, tx_valid/tx_data/tx_ready to the serializer, grant (one-hot owner), busy, abort; optional stall timeout under `HID_ARB_TIMEOUT_EN
module hid_uart_arbiter #(
  parameter int N = 3,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           abort
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [IW-1:0] last_idx_q, last_idx_d, own_idx, sel_idx;
  logic [IW:0] j;
  logic sel_found, hs, hs_last;
  assign grant = grant_q;
  assign busy = state_q == BUSY;
  assign req_ready = grant_q & {N{tx_ready}};
  assign tx_valid = |(grant_q & req_valid);
  assign hs = tx_valid & tx_ready;
  assign hs_last = |(grant_q & req_valid & req_last) & tx_ready;
  always_comb begin
    own_idx = '0;
    tx_data = '0;
    for (int i = 0; i < N; i++) begin
      own_idx = grant_q[i] ? IW'(i) : own_idx;
      tx_data = grant_q[i] ? req_data[8*i +: 8] : tx_data;
    end
  end
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = {1'b0, last_idx_q} + (IW+1)'(k);
      j = j >= (IW+1)'(N) ? j - (IW+1)'(N) : j;
      if (!sel_found && req_valid[j[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx = j[IW-1:0];
      end
    end
  end
`ifdef HID_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic abort_q, abort_d;
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_idx_d = last_idx_q;
`ifdef HID_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    abort_d = 1'b0;
`endif
    if (state_q == IDLE) begin
      state_d = sel_found ? BUSY : IDLE;
      grant_d = sel_found ? N'(1) << sel_idx : '0;
`ifdef HID_ARB_TIMEOUT_EN
      stall_cnt_d = '0;
`endif
    end else if (hs_last) begin
      state_d = IDLE;
      grant_d = '0;
      last_idx_d = own_idx;
`ifdef HID_ARB_TIMEOUT_EN
    end else if (!hs && stall_cnt_q == 16'(TIMEOUT)) begin
      state_d = IDLE;
      grant_d = '0;
      last_idx_d = own_idx;
      abort_d = 1'b1;
    end else begin
      stall_cnt_d = hs ? '0 : tx_valid ? stall_cnt_q : stall_cnt_q + 16'd1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_idx_q <= IW'(N - 1);
`ifdef HID_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_idx_q <= last_idx_d;
`ifdef HID_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
      abort_q <= abort_d;
`endif
    end
  end
endmodule

// File: tb/tb_hid_uart_arbiter.sv
// tb_hid_uart_arbiter: directed and randomized checks of hid_uart_arbiter against a queue-free behavioural model
module tb_hid_uart_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst = 0, trdy = 0;
  logic [2:0] v = 0, l = 0, rr, g;
  logic [23:0] d = 0;
  logic txv, busy, abort;
  logic [7:0] txd;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  hid_uart_arbiter #(.N(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_data(d), .req_last(l), .req_ready(rr),
    .tx_valid(txv), .tx_data(txd), .tx_ready(trdy), .grant(g), .busy(busy), .abort(abort)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; v = 0; l = 0; d = 0; trdy = 0;
    tick;
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1; v = 0; l = 0; d = 0; trdy = 0;
    tick;
    tick;
    #1;
    checks++; if (g !== 3'b000) begin fails++; $display("FAIL reset_grant got %b want 000", g); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (abort !== 1'b0) begin fails++; $display("FAIL reset_abort got %b want 0", abort); end
    checks++; if (txv !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", txv); end
    checks++; if (txd !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", txd); end
    checks++; if (rr !== 3'b000) begin fails++; $display("FAIL reset_req_ready got %b want 000", rr); end
    rst = 0;
  endtask
  task automatic test_single_packet;
    logic [7:0] pkt [3] = '{8'h41, 8'h42, 8'h0A};
    do_reset;
    v[1] = 1; d[15:8] = pkt[0]; trdy = 1;
    #1;
    checks++; if (txv !== 1'b0) begin fails++; $display("FAIL single_idle_tx_valid got %b want 0", txv); end
    tick;
    checks++; if (g !== 3'b010) begin fails++; $display("FAIL single_grant got %b want 010", g); end
    for (int i = 0; i < 3; i++) begin
      d[15:8] = pkt[i]; l[1] = (i == 2);
      #1;
      checks++; if (txd !== pkt[i] || txv !== 1'b1) begin fails++; $display("FAIL single_byte%0d got %h/%b want %h/1", i, txd, txv, pkt[i]); end
      checks++; if (rr !== 3'b010) begin fails++; $display("FAIL single_ready%0d got %b want 010", i, rr); end
      tick;
    end
    v = 0; l = 0;
    #1;
    checks++; if (busy !== 1'b0 || g !== 3'b000) begin fails++; $display("FAIL single_end got busy=%b grant=%b want 0/000", busy, g); end
  endtask
  task automatic test_round_robin;
    int pos [3] = '{0, 0, 0};
    int exp_own;
    do_reset;
    v = 3'b111; trdy = 1;
    for (int p = 0; p < 4; p++) begin
      exp_own = p % 3;
      for (int i = 0; i < 3; i++) begin d[8*i +: 8] = 8'(16*i + pos[i]); l[i] = (pos[i] == 1); end
      #1;
      checks++; if (g !== 3'b000) begin fails++; $display("FAIL rr_gap%0d got %b want 000", p, g); end
      tick;
      checks++; if (g !== 3'(1 << exp_own)) begin fails++; $display("FAIL rr_grant%0d got %b want %b", p, g, 3'(1 << exp_own)); end
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 3; i++) begin d[8*i +: 8] = 8'(16*i + pos[i]); l[i] = (pos[i] == 1); end
        #1;
        checks++; if (txd !== 8'(16*exp_own + b)) begin fails++; $display("FAIL rr_data%0d_%0d got %h want %h", p, b, txd, 8'(16*exp_own + b)); end
        tick;
        pos[exp_own] = (pos[exp_own] + 1) % 2;
      end
    end
    v = 0; l = 0;
  endtask
  task automatic test_back_to_back;
    do_reset;
    v = 3'b011; l = 3'b011; d = 24'h00_B1_A0; trdy = 1;
    tick;
    checks++; if (g !== 3'b001) begin fails++; $display("FAIL b2b_first got %b want 001", g); end
    tick;
    tick;
    checks++; if (g !== 3'b010) begin fails++; $display("FAIL b2b_second got %b want 010", g); end
    tick;
    tick;
    checks++; if (g !== 3'b001) begin fails++; $display("FAIL b2b_third got %b want 001", g); end
    tick;
    v = 0; l = 0;
  endtask
  task automatic test_hold;
    int sent = 0, cyc = 0;
    do_reset;
    v = 3'b001; d[7:0] = 8'h10; trdy = 0;
    tick;
    checks++; if (g !== 3'b001) begin fails++; $display("FAIL hold_grant got %b want 001", g); end
    v[2] = 1; d[23:16] = 8'hEE; l[2] = 1;
    while (sent < 3 && cyc < 20) begin
      trdy = (cyc % 2) == 1; d[7:0] = 8'(16 + sent); l[0] = (sent == 2);
      #1;
      checks++; if (g !== 3'b001) begin fails++; $display("FAIL hold_owner%0d got %b want 001", cyc, g); end
      checks++; if (rr !== {2'b00, trdy}) begin fails++; $display("FAIL hold_ready%0d got %b want %b", cyc, rr, {2'b00, trdy}); end
      tick;
      if (trdy) sent++;
      cyc++;
    end
    checks++; if (sent != 3) begin fails++; $display("FAIL hold_bound got %0d bytes want 3", sent); end
    v[0] = 0; l[0] = 0; trdy = 1;
    #1;
    checks++; if (g !== 3'b000) begin fails++; $display("FAIL hold_release got %b want 000", g); end
    tick;
    checks++; if (g !== 3'b100) begin fails++; $display("FAIL hold_next got %b want 100", g); end
    tick;
    v = 0; l = 0;
  endtask
  task automatic test_timeout;
    int pulses = 0, at = -1;
    do_reset;
    v = 3'b011; l = 3'b010; d = 24'h00_77_55; trdy = 1;
    tick;
    checks++; if (g !== 3'b001) begin fails++; $display("FAIL to_grant got %b want 001", g); end
    tick;
    v[0] = 0;
`ifdef HID_ARB_TIMEOUT_EN
    for (int c = 0; c < 10; c++) begin
      #1;
      if (abort === 1'b1) begin pulses++; if (at < 0) at = c; end
      if (c == TO + 2) begin
        checks++; if (g !== 3'b010) begin fails++; $display("FAIL to_next_grant got %b want 010", g); end
      end
      tick;
    end
    checks++; if (pulses != 1) begin fails++; $display("FAIL to_pulses got %0d want 1", pulses); end
    checks++; if (at != TO + 1) begin fails++; $display("FAIL to_pulse_cycle got %0d want %0d", at, TO + 1); end
`else
    for (int c = 0; c < 10; c++) begin
      #1;
      if (abort !== 1'b0 || g !== 3'b001) pulses++;
      tick;
    end
    checks++; if (pulses != 0) begin fails++; $display("FAIL to_held got %0d bad cycles want 0", pulses); end
    v[0] = 1; l[0] = 1;
    tick;
    checks++; if (g !== 3'b000) begin fails++; $display("FAIL to_release got %b want 000", g); end
    tick;
    checks++; if (g !== 3'b010) begin fails++; $display("FAIL to_next_grant got %b want 010", g); end
`endif
    v = 0; l = 0;
  endtask
  task automatic test_reset_busy;
    do_reset;
    v = 3'b010; d[15:8] = 8'h7A; trdy = 0;
    tick;
    checks++; if (g !== 3'b010) begin fails++; $display("FAIL rb_grant got %b want 010", g); end
    l[1] = 1; trdy = 1; rst = 1;
    tick;
    rst = 0;
    #1;
    checks++; if (g !== 3'b000 || busy !== 1'b0 || txv !== 1'b0) begin fails++; $display("FAIL rb_state got grant=%b busy=%b txv=%b want 000/0/0", g, busy, txv); end
    v = 3'b111;
    tick;
    checks++; if (g !== 3'b001) begin fails++; $display("FAIL rb_rearb got %b want 001", g); end
    v = 0; l = 0;
  endtask
  task automatic test_random;
    int own = -1, last = 2, stall = 0, nxt;
    bit hs, exp_abort = 0, nabort;
    logic [2:0] hold = 0, e_g, e_rr;
    logic e_txv;
    logic [7:0] e_txd;
    do_reset;
    repeat (400) begin
      for (int i = 0; i < 3; i++)
        if (!hold[i]) begin v[i] = 1'($urandom % 2); d[8*i +: 8] = 8'($urandom); l[i] = ($urandom % 3) == 0; end
      trdy = ($urandom % 4) != 0;
      #1;
      e_g = 0; e_txv = 0; e_txd = 0; e_rr = 0;
      if (own >= 0) begin
        e_g = 3'(1 << own); e_txv = v[own]; e_txd = d[8*own +: 8]; e_rr = trdy ? e_g : 3'b000;
      end
      checks++;
      if ({g, (own >= 0), e_txv, e_txd, e_rr, exp_abort} !== {e_g, 1'b1, 1'b1, 8'h00, 3'b000, 1'b0} & 0 | {g, busy, txv, txd, rr, abort} !== {e_g, (own >= 0), e_txv, e_txd, e_rr, exp_abort}) begin
        fails++;
        $display("FAIL random got g=%b busy=%b txv=%b txd=%h rr=%b abort=%b want g=%b busy=%b txv=%b txd=%h rr=%b abort=%b",
                 g, busy, txv, txd, rr, abort, e_g, own >= 0, e_txv, e_txd, e_rr, exp_abort);
      end
      hold = v & ~e_rr;
      nabort = 0;
      if (own < 0) begin
        nxt = -1;
        for (int k = 1; k <= 3; k++) if (nxt < 0 && v[(last + k) % 3]) nxt = (last + k) % 3;
        own = nxt; stall = 0;
      end else begin
        hs = v[own] && trdy;
        if (hs && l[own]) begin last = own; own = -1; end
`ifdef HID_ARB_TIMEOUT_EN
        else if (!hs && stall == TO) begin last = own; own = -1; nabort = 1; end
        else stall = hs ? 0 : (v[own] ? stall : stall + 1);
`endif
      end
      exp_abort = nabort;
      tick;
    end
    v = 0; l = 0;
  endtask
  initial begin
    test_reset;
    test_single_packet;
    test_round_robin;
    test_back_to_back;
    test_hold;
    test_timeout;
    test_reset_busy;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
